// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - single-port data RAM arbiter, CPU priority with starvation-forced debug grant
module dmem_arbiter #(
    parameter int STARVE_LIMIT = 8,
    parameter int AW           = 32,
    parameter int DW           = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cpu_cs,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic [DW-1:0] cpu_rdata,
    output logic          cpu_stall,
    input  logic          dbg_req,
    input  logic          dbg_we,
    input  logic [AW-1:0] dbg_addr,
    input  logic [DW-1:0] dbg_wdata,
    output logic          dbg_ack,
    output logic [DW-1:0] dbg_rdata,
    output logic          mem_ena,
    output logic          mem_wena,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic [15:0]   force_cnt
);

    typedef enum logic [1:0] {IDLE, WAIT, FORCE, ACK} state_t;

    localparam logic [7:0] LIMIT_M1 = 8'(STARVE_LIMIT - 1);

    state_t        state;
    logic [7:0]    starve_cnt;
    logic          lat_we;
    logic [AW-1:0] lat_addr;
    logic [DW-1:0] lat_wdata;
    logic [DW-1:0] rdata_q;
    logic [15:0]   force_cnt_q;
    logic          ack_q;
    logic          dbg_owns;

    // Debug master owns the RAM on an idle CPU cycle in WAIT, or unconditionally in FORCE.
    assign dbg_owns  = ((state == WAIT) && !cpu_cs) || (state == FORCE);
    assign cpu_stall = (state == FORCE);
    assign cpu_rdata = mem_rdata;
    assign dbg_ack   = ack_q;
    assign dbg_rdata = rdata_q;
    assign force_cnt = force_cnt_q;

    always_comb begin
        mem_ena   = cpu_cs;
        mem_wena  = cpu_cs & cpu_we;
        mem_addr  = cpu_addr;
        mem_wdata = cpu_wdata;
        if (dbg_owns) begin
            mem_ena   = 1'b1;
            mem_wena  = lat_we;
            mem_addr  = lat_addr;
            mem_wdata = lat_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            starve_cnt  <= 8'd0;
            lat_we      <= 1'b0;
            lat_addr    <= '0;
            lat_wdata   <= '0;
            rdata_q     <= '0;
            force_cnt_q <= 16'd0;
            ack_q       <= 1'b0;
        end else begin
            ack_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (dbg_req) begin
                        lat_we     <= dbg_we;
                        lat_addr   <= dbg_addr;
                        lat_wdata  <= dbg_wdata;
                        starve_cnt <= 8'd0;
                        state      <= WAIT;
                    end
                end
                WAIT: begin
                    if (!cpu_cs) begin
                        if (!lat_we) rdata_q <= mem_rdata;
                        starve_cnt <= 8'd0;
                        ack_q      <= 1'b1;
                        state      <= ACK;
                    end else if (starve_cnt == LIMIT_M1) begin
                        starve_cnt <= 8'd0;
                        state      <= FORCE;
                    end else begin
                        starve_cnt <= starve_cnt + 8'd1;
                    end
                end
                FORCE: begin
                    if (!lat_we) rdata_q <= mem_rdata;
                    if (force_cnt_q != 16'hFFFF) force_cnt_q <= force_cnt_q + 16'd1;
                    ack_q <= 1'b1;
                    state <= ACK;
                end
                ACK: begin
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single-port data RAM between the CPU and a debug/display master (req/ack), e.g. a memory scanner feeding the 7-segment display.
- Sits between cpu54 / debug master and ram.
- CPU has fixed priority. A starvation counter forces one stalled CPU cycle so the debug master always completes.

Parameters:
- STARVE_LIMIT, 8, consecutive CPU-busy WAIT cycles tolerated before forcing a debug grant; legal range 1..255.
- AW, 32, address width.
- DW, 32, data width.

Ports:
- clk  in  1  system clock; all state updates on rising edge. One clock only.
- rst  in  1  synchronous, active-high reset.
- cpu_cs  in  1  CPU memory access enable.
- cpu_we  in  1  CPU write enable, qualified by cpu_cs.
- cpu_addr  in  AW  CPU address.
- cpu_wdata  in  DW  CPU write data.
- cpu_rdata  out  DW  combinational copy of mem_rdata.
- cpu_stall  out  1  CPU must hold its request and not advance.
- dbg_req  in  1  debug request; sampled only in IDLE.
- dbg_we  in  1  debug write enable.
- dbg_addr  in  AW  debug address.
- dbg_wdata  in  DW  debug write data.
- dbg_ack  out  1  one-cycle completion pulse.
- dbg_rdata  out  DW  registered read data, valid from dbg_ack onward.
- mem_ena  out  1  to ram ena.
- mem_wena  out  1  to ram wena.
- mem_addr  out  AW  to ram addr.
- mem_wdata  out  DW  to ram data_in.
- mem_rdata  in  DW  from ram data_out; combinational read, synchronous write.
- force_cnt  out  16  number of forced grants, saturating at 16'hFFFF.

Behaviour:
- Reset (rst=1 at an edge):
  - state=IDLE, starve_cnt=0, dbg_rdata=0, force_cnt=0, dbg_ack=0.
  - Latched debug request is discarded and no ack is issued.
  - cpu_stall=0 while in IDLE.
- States: IDLE, WAIT, FORCE, ACK.
- IDLE:
  - mem_* = cpu_* (mem_ena=cpu_cs, mem_wena=cpu_cs&cpu_we).
  - If dbg_req=1: latch dbg_we/dbg_addr/dbg_wdata, go to WAIT.
- WAIT, cpu_cs=0 this cycle:
  - mem_* driven from the latched debug request, mem_ena=1.
  - At the edge: dbg_rdata<=mem_rdata (reads only; writes leave it unchanged), go to ACK, starve_cnt<=0.
- WAIT, cpu_cs=1:
  - CPU owns mem, starve_cnt<=starve_cnt+1.
  - If starve_cnt==STARVE_LIMIT-1: go to FORCE, starve_cnt<=0.
- FORCE:
  - cpu_stall=1 (combinational, this state only).
  - mem_* driven from the latched debug request; CPU request not forwarded.
  - At the edge: capture dbg_rdata as in WAIT, force_cnt<=force_cnt+1 (saturating), go to ACK.
- ACK:
  - dbg_ack=1 for exactly this cycle; CPU owns mem; go to IDLE.
  - dbg_req is ignored in ACK; a new request is sampled in IDLE next cycle.
- Latency:
  - Uncontended: req seen in IDLE at cycle 0, access at cycle 1, ack at cycle 2.
  - Worst case: ack at cycle STARVE_LIMIT+2.
- dbg_req held high continuously produces back-to-back transactions every 3 cycles minimum.
- cpu_stall is never asserted outside FORCE. At most one stall cycle per debug transaction.
- Debug write then CPU read of the same address in the following cycle returns the new data (RAM write commits at the FORCE/WAIT edge).

Test Plan:
- Reset: rst=1 for 2 cycles mid-WAIT with cpu_cs=1 -> state IDLE, dbg_ack never pulses, force_cnt=0, cpu_stall=0, dbg_rdata=0.
- Uncontended read: preload RAM[0x10]=0xDEADBEEF, cpu_cs=0, dbg_req pulse with addr 0x10 -> mem_addr=0x10 at cycle 1, dbg_ack at cycle 2, dbg_rdata=0xDEADBEEF.
- CPU priority: cpu_cs=1 for 3 cycles then 0, STARVE_LIMIT=8, debug write 0x12345678 to 0x20 -> cpu_stall stays 0, write occurs on the first cpu_cs=0 cycle, ack one cycle later, RAM[0x20]=0x12345678.
- Starvation: cpu_cs=1 permanently, STARVE_LIMIT=4, debug read -> WAIT 4 cycles, then FORCE with cpu_stall=1 for exactly 1 cycle, ack on the next cycle, force_cnt=1.
- Back-to-back: dbg_req held high, cpu_cs=0, 4 reads at addresses 0,4,8,12 (addresses changed right after each ack) -> acks every 3 cycles, data correct per address.
- Saturation: force_cnt preloaded by running 65536 forced transactions (or via a forced internal value in the bench) -> force_cnt stays 16'hFFFF on the next forced grant.
